uart_tx_fifo: RTL and testbench
===============================

UART_TX_FIFO -- requirements
Module: uart_tx_fifo

Interface
REQ-001 The block SHALL have parameter WIDTH, default 8, meaning data word width in bits.
REQ-002 The block SHALL have parameter DEPTH, default 16, meaning number of entries; power of two, >= 2.
REQ-003 The block SHALL have port clk  input  1  rising-edge clock.
REQ-004 The block SHALL have port rst  input  1  reset, synchronous, active-high.
REQ-005 The block SHALL have port flush  input  1  synchronous clear of FIFO contents.
REQ-006 The block SHALL have port wr_en  input  1  push request from the CPU-side UART data register.
REQ-007 The block SHALL have port wr_data  input  WIDTH  byte to push.
REQ-008 The block SHALL have port out_valid  output  1  head entry available; drives serializer i_valid.
REQ-009 The block SHALL have port out_data  output  WIDTH  head entry; drives serializer i_data.
REQ-010 The block SHALL have port out_ready  input  1  serializer o_ready.
REQ-011 The block SHALL have port full  output  1  count == DEPTH.
REQ-012 The block SHALL have port empty  output  1  count == 0.
REQ-013 The block SHALL have port count  output  $clog2(DEPTH)+1  current occupancy.
REQ-014 The block SHALL have port overflow  output  1  sticky flag: a push was dropped.

Function
REQ-015 Push SHALL occur on a clk edge when wr_en=1 and (full=0 or pop occurs the same cycle).
REQ-016 Pop SHALL occur on a clk edge when out_valid=1 and out_ready=1.
REQ-017 out_valid SHALL equal !empty; out_data SHALL be the head entry (show-ahead, no read latency).
REQ-018 out_data SHALL hold stable while out_valid=1 and out_ready=0.
REQ-019 A push into an empty FIFO SHALL make out_valid=1 on the cycle after the push edge, never on the same cycle.
REQ-020 Simultaneous push and pop SHALL leave count unchanged; the new byte is written at the tail.
REQ-021 wr_en=1 with full=1 and no same-cycle pop SHALL drop the byte, leave contents and count unchanged, and set overflow=1.
REQ-022 overflow SHALL stay 1 until rst or flush.
REQ-023 Read and write pointers SHALL be $clog2(DEPTH) bits and wrap from DEPTH-1 to 0; count SHALL be tracked separately, saturating at DEPTH and 0.
REQ-024 flush=1 SHALL, at the next edge, zero pointers, count and overflow; a same-cycle wr_en or pop SHALL be ignored (flush wins).
REQ-025 Bytes SHALL be emitted in strict push order, with no duplication or loss other than REQ-021 drops.
REQ-026 full, empty and count SHALL be registered-state-derived, with no combinational path from wr_en or out_ready.

Reset
REQ-027 On rst=1 at a clk edge: pointers=0, count=0, overflow=0; hence empty=1, full=0, out_valid=0.
REQ-028 Storage contents SHALL NOT require reset; out_data is don't-care while out_valid=0.
REQ-029 rst asserted mid-operation SHALL discard all entries and abort any pending handshake at that edge; rst has priority over flush, wr_en and pop.

Structure
REQ-030 UART_FIFO_DEPTH and UART_DATA_WIDTH defaults and count-width derivation SHALL live in the shared package uart_pkg.
REQ-031 Storage SHALL be a sub-module uart_fifo_ram: 1 write port, 1 asynchronous read port, no reset.
REQ-032 Pointer, count, overflow and handshake logic SHALL reside in uart_tx_fifo.
REQ-033 The block SHALL be instantiated between the UART data register (push on data-register write strobe) and the serializer (out_valid/out_data/out_ready).

Verification
REQ-034 Test 1: after rst, push 0x41, 0x42, 0x43 with out_ready=0 -> count=3, out_data=0x41; then out_ready=1 for 3 cycles -> bytes 0x41, 0x42, 0x43 in order, empty=1.
REQ-035 Test 2: push 17 bytes 0x00..0x10 with out_ready=0 (DEPTH=16) -> full=1 after the 16th, 0x10 dropped, overflow=1, count=16; drain -> 0x00..0x0F.
REQ-036 Test 3: full FIFO, wr_en=1 and out_ready=1 same cycle -> count stays 16, overflow stays 0, new byte emerges last.
REQ-037 Test 4: 40 push/pop pairs at random spacing -> pointer wrap exercised, output sequence equals input sequence.
REQ-038 Test 5: 5 entries plus overflow=1, assert flush with wr_en=1 -> next cycle count=0, empty=1, overflow=0, pushed byte absent.
REQ-039 Test 6: rst asserted with 3 entries and out_ready=1 -> next cycle out_valid=0, count=0; subsequent push 0x55 appears as head.

Source files
------------

// File: rtl/uart_pkg.sv
// Shared UART constants: default data width, TX FIFO depth and the
// occupancy-counter width derivation used by the FIFO ports.
package uart_pkg;

    localparam int UART_DATA_WIDTH = 8;
    localparam int UART_FIFO_DEPTH = 16;

    // Occupancy must represent 0..depth inclusive, hence one extra bit.
    function automatic int count_width(input int depth);
        return $clog2(depth) + 1;
    endfunction

endpackage

// File: rtl/uart_fifo_ram.sv
// TX FIFO storage: one synchronous write port, one asynchronous read port,
// contents never reset so it maps onto distributed RAM.
module uart_fifo_ram
    import uart_pkg::*;
#(
    parameter int WIDTH = UART_DATA_WIDTH,
    parameter int DEPTH = UART_FIFO_DEPTH
) (
    input  logic                     clk,
    input  logic                     we,
    input  logic [$clog2(DEPTH)-1:0] waddr,
    input  logic [WIDTH-1:0]         wdata,
    input  logic [$clog2(DEPTH)-1:0] raddr,
    output logic [WIDTH-1:0]         rdata
);

    logic [WIDTH-1:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
    end

    // Show-ahead read: the head entry is visible without a read cycle.
    assign rdata = mem[raddr];

endmodule

// File: rtl/uart_tx_fifo.sv
// Transmit FIFO between the UART data register and the serializer:
// show-ahead valid/ready output, sticky overflow on dropped pushes.
module uart_tx_fifo
    import uart_pkg::*;
#(
    parameter int WIDTH = UART_DATA_WIDTH,
    parameter int DEPTH = UART_FIFO_DEPTH
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          flush,
    input  logic                          wr_en,
    input  logic [WIDTH-1:0]              wr_data,
    output logic                          out_valid,
    output logic [WIDTH-1:0]              out_data,
    input  logic                          out_ready,
    output logic                          full,
    output logic                          empty,
    output logic [count_width(DEPTH)-1:0] count,
    output logic                          overflow
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = count_width(DEPTH);
    localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(DEPTH);

    logic [PTR_W-1:0] wr_ptr_reg, wr_ptr_next;
    logic [PTR_W-1:0] rd_ptr_reg, rd_ptr_next;
    logic [CNT_W-1:0] count_reg, count_next;
    logic             overflow_reg, overflow_next;
    logic             push, pop, ram_we;

    // Status flags come only from registered count, so wr_en/out_ready
    // never reach them combinationally.
    assign empty     = (count_reg == '0);
    assign full      = (count_reg == DEPTH_C);
    assign count     = count_reg;
    assign overflow  = overflow_reg;
    assign out_valid = !empty;

    assign pop    = out_valid && out_ready;
    assign push   = wr_en && (!full || pop);
    assign ram_we = push && !rst && !flush;

    always_comb begin
        wr_ptr_next   = wr_ptr_reg;
        rd_ptr_next   = rd_ptr_reg;
        count_next    = count_reg;
        overflow_next = overflow_reg;
        if (rst || flush) begin
            wr_ptr_next   = '0;
            rd_ptr_next   = '0;
            count_next    = '0;
            overflow_next = 1'b0;
        end else begin
            if (push) begin
                wr_ptr_next = wr_ptr_reg + 1'b1;
            end
            if (pop) begin
                rd_ptr_next = rd_ptr_reg + 1'b1;
            end
            if (push && !pop) begin
                count_next = count_reg + 1'b1;
            end else if (pop && !push) begin
                count_next = count_reg - 1'b1;
            end
            if (wr_en && !push) begin
                overflow_next = 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        wr_ptr_reg   <= wr_ptr_next;
        rd_ptr_reg   <= rd_ptr_next;
        count_reg    <= count_next;
        overflow_reg <= overflow_next;
    end

    uart_fifo_ram #(
        .WIDTH (WIDTH),
        .DEPTH (DEPTH)
    ) u_ram (
        .clk   (clk),
        .we    (ram_we),
        .waddr (wr_ptr_reg),
        .wdata (wr_data),
        .raddr (rd_ptr_reg),
        .rdata (out_data)
    );

endmodule

// File: tb/tb_uart_tx_fifo.sv
// Scoreboard bench for uart_tx_fifo: stimulus queues expected bytes,
// a negedge monitor checks every accepted output against the queue.
module tb_uart_tx_fifo;

    localparam int WIDTH = 8;
    localparam int DEPTH = 16;

    logic             clk = 1'b0;
    logic             rst = 1'b0;
    logic             flush = 1'b0;
    logic             wr_en = 1'b0;
    logic [WIDTH-1:0] wr_data = '0;
    logic             out_valid;
    logic [WIDTH-1:0] out_data;
    logic             out_ready = 1'b0;
    logic             full;
    logic             empty;
    logic [4:0]       count;
    logic             overflow;

    int n_checks = 0;
    int n_fail   = 0;
    logic [WIDTH-1:0] exp_q [$];

    uart_tx_fifo #(
        .WIDTH (WIDTH),
        .DEPTH (DEPTH)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .flush     (flush),
        .wr_en     (wr_en),
        .wr_data   (wr_data),
        .out_valid (out_valid),
        .out_data  (out_data),
        .out_ready (out_ready),
        .full      (full),
        .empty     (empty),
        .count     (count),
        .overflow  (overflow)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end else begin
            $display("ok   %s: 0x%0h", name, act);
        end
    endtask

    // Monitor: a handshake seen at negedge is consumed at the next posedge
    // unless rst or flush aborts it.
    always @(negedge clk) begin
        if (out_valid === 1'b1 && out_ready && !rst && !flush) begin
            if (exp_q.size() == 0) begin
                n_checks++;
                n_fail++;
                $display("FAIL unexpected_output: got 0x%0h expected none", out_data);
            end else begin
                check("out_byte", 32'(out_data), 32'(exp_q.pop_front()));
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst       = 1'b1;
        flush     = 1'b0;
        wr_en     = 1'b0;
        out_ready = 1'b0;
        exp_q.delete();
        tick();
        rst = 1'b0;
    endtask

    task automatic push_byte(input logic [WIDTH-1:0] b, input bit accepted);
        wr_en   = 1'b1;
        wr_data = b;
        if (accepted) exp_q.push_back(b);
        tick();
        wr_en = 1'b0;
    endtask

    task automatic drain(input string name, input int max_cycles);
        out_ready = 1'b1;
        for (int k = 0; k < max_cycles && empty !== 1'b1; k++) tick();
        out_ready = 1'b0;
        check({name, "_empty"}, 32'(empty), 32'd1);
        check({name, "_all_seen"}, 32'(exp_q.size()), 32'd0);
    endtask

    initial begin
        int model_cnt;
        int pushed;
        int cycles;
        bit pop_m;
        bit push_m;

        // Test 1: basic order and reset state
        do_reset();
        check("rst_count", 32'(count), 32'd0);
        check("rst_empty", 32'(empty), 32'd1);
        check("rst_full", 32'(full), 32'd0);
        check("rst_out_valid", 32'(out_valid), 32'd0);
        check("rst_overflow", 32'(overflow), 32'd0);
        wr_en = 1'b1; wr_data = 8'h41;
        exp_q.push_back(8'h41);
        #1;
        check("t1_no_same_cycle_valid", 32'(out_valid), 32'd0);
        tick();
        wr_en = 1'b0;
        check("t1_valid_after_push", 32'(out_valid), 32'd1);
        push_byte(8'h42, 1'b1);
        push_byte(8'h43, 1'b1);
        check("t1_count", 32'(count), 32'd3);
        check("t1_head", 32'(out_data), 32'h41);
        tick();
        check("t1_head_stable", 32'(out_data), 32'h41);
        out_ready = 1'b1;
        repeat (3) tick();
        out_ready = 1'b0;
        check("t1_empty", 32'(empty), 32'd1);
        check("t1_all_seen", 32'(exp_q.size()), 32'd0);

        // Test 2: overflow drops the 17th byte
        do_reset();
        for (int i = 0; i < 17; i++) begin
            push_byte(8'(i), i < 16);
            if (i == 15) check("t2_full_after_16", 32'(full), 32'd1);
        end
        check("t2_overflow", 32'(overflow), 32'd1);
        check("t2_count", 32'(count), 32'd16);
        drain("t2", 40);
        check("t2_overflow_sticky", 32'(overflow), 32'd1);

        // Test 3: push and pop on a full FIFO
        do_reset();
        for (int i = 0; i < 16; i++) push_byte(8'(8'hA0 + i), 1'b1);
        check("t3_full", 32'(full), 32'd1);
        wr_en = 1'b1; wr_data = 8'hEE; out_ready = 1'b1;
        exp_q.push_back(8'hEE);
        tick();
        wr_en = 1'b0; out_ready = 1'b0;
        check("t3_count", 32'(count), 32'd16);
        check("t3_overflow", 32'(overflow), 32'd0);
        drain("t3", 40);

        // Test 4: 40 pushes with random spacing and random backpressure
        do_reset();
        model_cnt = 0; pushed = 0; cycles = 0;
        while (pushed < 40 && cycles < 2000) begin
            out_ready = ($urandom_range(0, 3) != 0);
            wr_en     = (model_cnt < DEPTH) && ($urandom_range(0, 1) == 1);
            wr_data   = 8'(8'hC0 + pushed);
            pop_m     = (model_cnt > 0) && out_ready;
            push_m    = wr_en;
            if (push_m) begin
                exp_q.push_back(wr_data);
                pushed++;
            end
            tick();
            model_cnt = model_cnt + int'(push_m) - int'(pop_m);
            cycles++;
        end
        wr_en = 1'b0;
        check("t4_count_model", 32'(count), 32'(model_cnt));
        drain("t4", 40);

        // Test 5: flush beats a same-cycle push
        do_reset();
        for (int i = 0; i < 17; i++) push_byte(8'(8'h20 + i), i < 16);
        out_ready = 1'b1;
        repeat (11) tick();
        out_ready = 1'b0;
        check("t5_count5", 32'(count), 32'd5);
        check("t5_overflow_set", 32'(overflow), 32'd1);
        flush = 1'b1; wr_en = 1'b1; wr_data = 8'h99;
        exp_q.delete();
        tick();
        flush = 1'b0; wr_en = 1'b0;
        check("t5_count", 32'(count), 32'd0);
        check("t5_empty", 32'(empty), 32'd1);
        check("t5_overflow", 32'(overflow), 32'd0);
        push_byte(8'h77, 1'b1);
        check("t5_head_after_flush", 32'(out_data), 32'h77);
        drain("t5", 10);

        // Test 6: rst aborts a pending handshake
        do_reset();
        push_byte(8'h10, 1'b1);
        push_byte(8'h11, 1'b1);
        push_byte(8'h12, 1'b1);
        rst = 1'b1; out_ready = 1'b1;
        exp_q.delete();
        tick();
        rst = 1'b0; out_ready = 1'b0;
        check("t6_out_valid", 32'(out_valid), 32'd0);
        check("t6_count", 32'(count), 32'd0);
        push_byte(8'h55, 1'b1);
        check("t6_head", 32'(out_data), 32'h55);
        check("t6_count1", 32'(count), 32'd1);
        drain("t6", 10);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
